// File: rtl/key_cmd_gen.sv
// Turns a raw USB keycode into single-frame mover commands,
// with delayed auto-repeat for left/right/down and one-shot keys.
module key_cmd_gen #(
  parameter int unsigned DAS_DELAY   = 16,
  parameter int unsigned ARR_PERIOD  = 6,
  parameter int unsigned SOFT_PERIOD = 2
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic        enable,
  input  logic [7:0]  raw_keycode,
  output logic [7:0]  keycode,
  output logic        cmd_valid,
  output logic        is_repeat,
  output logic [15:0] cmd_count
);

  localparam logic [7:0] K_LEFT  = 8'h50;
  localparam logic [7:0] K_RIGHT = 8'h4F;
  localparam logic [7:0] K_DOWN  = 8'h51;
  localparam logic [7:0] K_UP    = 8'h52;
  localparam logic [7:0] K_SPACE = 8'h2C;
  localparam logic [7:0] K_Z     = 8'h1D;
  localparam logic [7:0] K_X     = 8'h1B;

  localparam logic [7:0] L_DAS  = 8'(DAS_DELAY - 1);
  localparam logic [7:0] L_ARR  = 8'(ARR_PERIOD - 1);
  localparam logic [7:0] L_SOFT = 8'(SOFT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT,
    HOLD
  } state_t;

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [7:0]  r_key;
  logic [7:0]  r_keycode;
  logic        r_valid;
  logic        r_rep;
  logic [15:0] r_count;

  logic       w_rpt_key;
  logic       w_shot_key;
  logic       w_recog;
  logic [7:0] w_dly;
  logic [7:0] w_arr;
  logic       w_fresh;
  logic       w_emit;
  logic       w_rep;

  assign w_rpt_key  = (raw_keycode == K_LEFT) ||
                      (raw_keycode == K_RIGHT) ||
                      (raw_keycode == K_DOWN);
  assign w_shot_key = (raw_keycode == K_UP) ||
                      (raw_keycode == K_SPACE) ||
                      (raw_keycode == K_Z) ||
                      (raw_keycode == K_X);
  assign w_recog    = w_rpt_key || w_shot_key;

  // Down uses the soft-drop period for both first delay and repeat.
  assign w_dly = (r_key == K_DOWN) ? L_SOFT : L_DAS;
  assign w_arr = (r_key == K_DOWN) ? L_SOFT : L_ARR;

  always_comb begin
    w_fresh = 1'b0;
    w_emit  = 1'b0;
    w_rep   = 1'b0;
    if (enable && w_recog) begin
      if (r_state == IDLE || raw_keycode != r_key) begin
        w_fresh = 1'b1;
        w_emit  = 1'b1;
      end else begin
        unique case (r_state)
          DELAY: begin
            w_emit = (r_cnt == w_dly);
            w_rep  = (r_cnt == w_dly);
          end
          REPEAT: begin
            w_emit = (r_cnt == w_arr);
            w_rep  = (r_cnt == w_arr);
          end
          HOLD: begin
            w_emit = 1'b0;
          end
          IDLE: begin
            w_emit = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_cnt     <= 8'h00;
      r_key     <= 8'h00;
      r_keycode <= 8'h00;
      r_valid   <= 1'b0;
      r_rep     <= 1'b0;
      r_count   <= 16'h0000;
    end else begin
      r_keycode <= w_emit ? raw_keycode : 8'h00;
      r_valid   <= w_emit;
      r_rep     <= w_rep;
      if (w_emit)
        r_count <= r_count + 16'd1;

      if (!enable || !w_recog) begin
        r_state <= IDLE;
        r_cnt   <= 8'h00;
        r_key   <= 8'h00;
      end else if (w_fresh) begin
        r_key   <= raw_keycode;
        r_cnt   <= 8'h00;
        r_state <= w_rpt_key ? DELAY : HOLD;
      end else begin
        unique case (r_state)
          DELAY: begin
            if (w_emit) begin
              r_cnt   <= 8'h00;
              r_state <= REPEAT;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
          REPEAT: begin
            if (w_emit)
              r_cnt <= 8'h00;
            else
              r_cnt <= r_cnt + 8'd1;
          end
          HOLD: begin
            r_cnt <= 8'h00;
          end
          IDLE: begin
            r_cnt <= 8'h00;
          end
        endcase
      end
    end
  end

  assign keycode   = r_keycode;
  assign cmd_valid = r_valid;
  assign is_repeat = r_rep;
  assign cmd_count = r_count;

endmodule

// File: tb/tb_key_cmd_gen.sv
// Scoreboard bench for key_cmd_gen: stimulus queues expected
// pulses, a negedge monitor pops and compares them.
module tb_key_cmd_gen;

  logic        frame_clk;
  logic        Reset;
  logic        enable;
  logic [7:0]  raw_keycode;
  logic [7:0]  keycode;
  logic        cmd_valid;
  logic        is_repeat;
  logic [15:0] cmd_count;

  key_cmd_gen dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .enable      (enable),
    .raw_keycode (raw_keycode),
    .keycode     (keycode),
    .cmd_valid   (cmd_valid),
    .is_repeat   (is_repeat),
    .cmd_count   (cmd_count)
  );

  typedef struct {
    int          e;
    logic [7:0]  k;
    logic        r;
    logic [15:0] c;
  } exp_t;

  exp_t        q[$];
  int          checks   = 0;
  int          failures = 0;
  int          edge_n   = 0;
  logic [15:0] exp_cnt  = 16'h0000;

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  always @(posedge frame_clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at edge %0d: got %h expected %h",
               name, edge_n, act, exp);
    end
  endtask

  task automatic push(input int e, input logic [7:0] k,
                      input logic r);
    exp_t x;
    exp_cnt = exp_cnt + 16'd1;
    x.e = e;
    x.k = k;
    x.r = r;
    x.c = exp_cnt;
    q.push_back(x);
  endtask

  task automatic drive(input logic [7:0] k, input logic en,
                       input int n);
    repeat (n) begin
      raw_keycode = k;
      enable      = en;
      @(negedge frame_clk);
    end
  endtask

  // Monitor: compares every presented command against the queue.
  always @(negedge frame_clk) begin
    if (!Reset) begin
      chk("valid_vs_key", {31'b0, cmd_valid},
          {31'b0, keycode != 8'h00});
      if (is_repeat && !cmd_valid)
        chk("rep_without_valid", 32'd1, 32'd0);
      if (cmd_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_cmd", {24'b0, keycode}, 32'd0);
        end else begin
          exp_t x;
          x = q.pop_front();
          chk("edge", edge_n, x.e);
          chk("keycode", {24'b0, keycode}, {24'b0, x.k});
          chk("is_repeat", {31'b0, is_repeat}, {31'b0, x.r});
          chk("cmd_count", {16'b0, cmd_count}, {16'b0, x.c});
        end
      end
    end
  end

  int b;
  int s;

  initial begin
    Reset       = 1'b1;
    enable      = 1'b1;
    raw_keycode = 8'h00;
    #1;
    chk("rst_keycode", {24'b0, keycode}, 32'd0);
    chk("rst_valid", {31'b0, cmd_valid}, 32'd0);
    chk("rst_count", {16'b0, cmd_count}, 32'd0);
    @(negedge frame_clk);
    Reset = 1'b0;
    drive(8'h00, 1'b1, 2);

    // left held 40 frames
    b = edge_n + 1;
    push(b, 8'h50, 1'b0);
    push(b + 16, 8'h50, 1'b1);
    push(b + 22, 8'h50, 1'b1);
    push(b + 28, 8'h50, 1'b1);
    push(b + 34, 8'h50, 1'b1);
    drive(8'h50, 1'b1, 40);
    drive(8'h00, 1'b1, 3);
    chk("count_left", {16'b0, cmd_count}, 32'd5);

    // down held 7 frames
    b = edge_n + 1;
    push(b, 8'h51, 1'b0);
    push(b + 2, 8'h51, 1'b1);
    push(b + 4, 8'h51, 1'b1);
    push(b + 6, 8'h51, 1'b1);
    drive(8'h51, 1'b1, 7);
    drive(8'h00, 1'b1, 3);
    chk("count_down", {16'b0, cmd_count}, 32'd9);

    // space held, released via unrecognised code, re-pressed
    b = edge_n + 1;
    push(b, 8'h2C, 1'b0);
    push(b + 32, 8'h2C, 1'b0);
    drive(8'h2C, 1'b1, 30);
    drive(8'h04, 1'b1, 2);
    drive(8'h2C, 1'b1, 5);
    drive(8'h00, 1'b1, 3);
    chk("count_space", {16'b0, cmd_count}, 32'd11);

    // left switched directly to right
    b = edge_n + 1;
    s = b + 10;
    push(b, 8'h50, 1'b0);
    push(s, 8'h4F, 1'b0);
    push(s + 16, 8'h4F, 1'b1);
    drive(8'h50, 1'b1, 10);
    drive(8'h4F, 1'b1, 20);
    drive(8'h00, 1'b1, 3);
    chk("count_switch", {16'b0, cmd_count}, 32'd14);

    // right held across an enable gap
    b = edge_n + 1;
    push(b, 8'h4F, 1'b0);
    push(b + 16, 8'h4F, 1'b1);
    push(b + 25, 8'h4F, 1'b0);
    push(b + 41, 8'h4F, 1'b1);
    drive(8'h4F, 1'b1, 20);
    drive(8'h4F, 1'b0, 5);
    drive(8'h4F, 1'b1, 20);
    drive(8'h00, 1'b1, 3);
    chk("count_enable", {16'b0, cmd_count}, 32'd18);

    // one-shot to one-shot switches
    b = edge_n + 1;
    push(b, 8'h1D, 1'b0);
    push(b + 3, 8'h1B, 1'b0);
    push(b + 6, 8'h52, 1'b0);
    drive(8'h1D, 1'b1, 3);
    drive(8'h1B, 1'b1, 3);
    drive(8'h52, 1'b1, 3);
    drive(8'h00, 1'b1, 3);
    chk("count_oneshot", {16'b0, cmd_count}, 32'd21);

    // restart count, then reset mid-REPEAT
    Reset = 1'b1;
    @(negedge frame_clk);
    Reset = 1'b0;
    exp_cnt = 16'h0000;
    drive(8'h00, 1'b1, 2);
    b = edge_n + 1;
    push(b, 8'h50, 1'b0);
    push(b + 16, 8'h50, 1'b1);
    push(b + 22, 8'h50, 1'b1);
    drive(8'h50, 1'b1, 23);
    chk("count_pre_rst", {16'b0, cmd_count}, 32'd3);
    #2;
    Reset = 1'b1;
    #1;
    chk("midrst_keycode", {24'b0, keycode}, 32'd0);
    chk("midrst_valid", {31'b0, cmd_valid}, 32'd0);
    chk("midrst_rep", {31'b0, is_repeat}, 32'd0);
    chk("midrst_count", {16'b0, cmd_count}, 32'd0);
    @(negedge frame_clk);
    Reset = 1'b0;
    exp_cnt = 16'h0000;
    b = edge_n + 1;
    push(b, 8'h50, 1'b0);
    drive(8'h50, 1'b1, 5);
    drive(8'h00, 1'b1, 3);
    chk("count_post_rst", {16'b0, cmd_count}, 32'd1);

    chk("queue_drained", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
